// File: rtl/tdp_guard_pkg.sv
// Shared types for the true-dual-port collision guard.
// TDP_GUARD_FWD_EN selects write-to-read forwarding instead of stalling.
package tdp_guard_pkg;

  typedef enum logic [1:0] {
    COLL_NONE,
    COLL_WW,
    COLL_RW_A,
    COLL_RW_B
  } coll_e;

  localparam int CNT_W_DEF = 16;

`ifdef TDP_GUARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/tdp_guard_arb.sv
// Same-address hazard classifier and ready generator.
// Readiness of an RW reader depends on TDP_GUARD_FWD_EN.
module tdp_guard_arb
  import tdp_guard_pkg::*;
#(
  parameter int ABITS = 10
) (
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic [ABITS-1:0] a_addr,
  input  logic [ABITS-1:0] b_addr,
  input  logic             a_we,
  input  logic             b_we,
  input  logic             prio,
  output coll_e            coll,
  output logic             a_ready,
  output logic             b_ready
);

  logic same;

  assign same = a_valid & b_valid & (a_addr == b_addr);

  always_comb begin
    coll    = COLL_NONE;
    a_ready = 1'b1;
    b_ready = 1'b1;
    if (same) begin
      unique case (1'b1)
        a_we & b_we: begin
          coll    = COLL_WW;
          a_ready = ~prio;
          b_ready = prio;
        end
        a_we & ~b_we: begin
          coll    = COLL_RW_A;
          b_ready = FWD_EN;
        end
        ~a_we & b_we: begin
          coll    = COLL_RW_B;
          a_ready = FWD_EN;
        end
        ~a_we & ~b_we: begin
          coll = COLL_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/tdp_collision_guard.sv
// Hazard-free request front-end for a true-dual-port BRAM.
// TDP_GUARD_FWD_EN forwards write data to a same-address reader.
module tdp_collision_guard
  import tdp_guard_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 36,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [ABITS-1:0] a_addr,
  input  logic [DBITS-1:0] a_wd,
  input  logic             a_we,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [ABITS-1:0] b_addr,
  input  logic [DBITS-1:0] b_wd,
  input  logic             b_we,
  output logic [ABITS-1:0] ram_a_a,
  output logic [ABITS-1:0] ram_a_b,
  output logic [DBITS-1:0] ram_wd_a,
  output logic [DBITS-1:0] ram_wd_b,
  output logic             ram_we_a,
  output logic             ram_we_b,
  input  logic [DBITS-1:0] ram_rd_a,
  input  logic [DBITS-1:0] ram_rd_b,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [DBITS-1:0] a_rd,
  output logic [DBITS-1:0] b_rd,
  output logic [CNT_W-1:0] coll_cnt
);

  localparam logic [ABITS-1:0] A_ONE = ABITS'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  coll_e coll;
  logic  prio;
  logic  arb_a_ready, arb_b_ready;
  logic  a_acc, b_acc;
  logic  fwd_a, fwd_b, bump;
  logic  s1_a, s2_a, s1_b, s2_b;
  logic  f1_a, f2_a, f1_b, f2_b;
  logic [DBITS-1:0] fd1_a, fd2_a, fd1_b, fd2_b;

  tdp_guard_arb #(.ABITS(ABITS)) u_arb (
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .a_we    (a_we),
    .b_we    (b_we),
    .prio    (prio),
    .coll    (coll),
    .a_ready (arb_a_ready),
    .b_ready (arb_b_ready)
  );

  assign a_ready = arb_a_ready & rst_n;
  assign b_ready = arb_b_ready & rst_n;
  assign a_acc   = a_valid & a_ready;
  assign b_acc   = b_valid & b_ready;

  // A forwarding reader is steered off the written address.
  assign fwd_a = FWD_EN && (coll == COLL_RW_B);
  assign fwd_b = FWD_EN && (coll == COLL_RW_A);
  assign bump  = (coll == COLL_WW) ||
                 (!FWD_EN && (coll == COLL_RW_A || coll == COLL_RW_B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_a_a  <= '0;
      ram_a_b  <= '0;
      ram_wd_a <= '0;
      ram_wd_b <= '0;
      ram_we_a <= 1'b0;
      ram_we_b <= 1'b0;
      s1_a     <= 1'b0;
      s2_a     <= 1'b0;
      s1_b     <= 1'b0;
      s2_b     <= 1'b0;
      f1_a     <= 1'b0;
      f2_a     <= 1'b0;
      f1_b     <= 1'b0;
      f2_b     <= 1'b0;
      fd1_a    <= '0;
      fd2_a    <= '0;
      fd1_b    <= '0;
      fd2_b    <= '0;
      prio     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      ram_we_a <= a_acc & a_we;
      ram_we_b <= b_acc & b_we;
      if (a_acc) begin
        ram_a_a  <= fwd_a ? (a_addr ^ A_ONE) : a_addr;
        ram_wd_a <= a_wd;
      end
      if (b_acc) begin
        ram_a_b  <= fwd_b ? (b_addr ^ A_ONE) : b_addr;
        ram_wd_b <= b_wd;
      end
      s1_a <= a_acc & ~a_we;
      s2_a <= s1_a;
      s1_b <= b_acc & ~b_we;
      s2_b <= s1_b;
      f1_a <= a_acc & fwd_a;
      f2_a <= f1_a;
      f1_b <= b_acc & fwd_b;
      f2_b <= f1_b;
      if (a_acc & fwd_a) fd1_a <= b_wd;
      if (b_acc & fwd_b) fd1_b <= a_wd;
      fd2_a <= fd1_a;
      fd2_b <= fd1_b;
      if (coll == COLL_WW) prio <= ~prio;
      if (bump && coll_cnt != '1) coll_cnt <= coll_cnt + C_ONE;
    end
  end

  assign a_rvalid = s2_a;
  assign b_rvalid = s2_b;
  assign a_rd = s2_a ? (f2_a ? fd2_a : ram_rd_a) : '0;
  assign b_rd = s2_b ? (f2_b ? fd2_b : ram_rd_b) : '0;

endmodule

// File: tb/tb_tdp_collision_guard.sv
// Scoreboard bench for tdp_collision_guard with a behavioural TDP RAM.
// Expectations follow TDP_GUARD_FWD_EN when it is defined.
module tb_tdp_collision_guard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [9:0]  a_addr, b_addr;
  logic [35:0] a_wd, b_wd;
  logic        a_we, b_we;
  logic [9:0]  ram_a_a, ram_a_b;
  logic [35:0] ram_wd_a, ram_wd_b;
  logic        ram_we_a, ram_we_b;
  logic [35:0] ram_rd_a, ram_rd_b;
  logic        a_rvalid, b_rvalid;
  logic [35:0] a_rd, b_rd;
  logic [15:0] coll_cnt;

`ifdef TDP_GUARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int rva = 0;
  int rvb = 0;
  int cyc = 0;
  int we_a_cyc = 0;
  int we_b_cyc = 0;
  logic [35:0] qa[$];
  logic [35:0] qb[$];
  logic [35:0] mem[1024];

  tdp_collision_guard dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_wd(a_wd), .a_we(a_we),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_wd(b_wd), .b_we(b_we),
    .ram_a_a(ram_a_a), .ram_a_b(ram_a_b),
    .ram_wd_a(ram_wd_a), .ram_wd_b(ram_wd_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_rd_a(ram_rd_a), .ram_rd_b(ram_rd_b),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rd(a_rd), .b_rd(b_rd),
    .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we_a) mem[ram_a_a] <= ram_wd_a;
    if (ram_we_b) mem[ram_a_b] <= ram_wd_b;
    ram_rd_a <= mem[ram_a_a];
    ram_rd_b <= mem[ram_a_b];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we_a) we_a_cyc = cyc;
      if (ram_we_b) we_b_cyc = cyc;
      if (ram_we_a && ram_we_b && ram_a_a == ram_a_b) begin
        tests++;
        fails++;
        $display("FAIL ram_ww: both ports write %0h", ram_a_a);
      end
      if (a_rvalid) begin
        rva++;
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL a_rvalid: got unexpected data %0h, expected none", a_rd);
        end else chk("a_rd", 64'(a_rd), 64'(qa.pop_front()));
      end
      if (b_rvalid) begin
        rvb++;
        if (qb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL b_rvalid: got unexpected data %0h, expected none", b_rd);
        end else chk("b_rd", 64'(b_rd), 64'(qb.pop_front()));
      end
    end
  end

  task automatic req2(
    input logic av, input logic awe, input logic [9:0] aad,
    input logic [35:0] awd, input logic [35:0] aexp,
    input logic bv, input logic bwe, input logic [9:0] bad,
    input logic [35:0] bwd, input logic [35:0] bexp,
    output int aw, output int bw);
    logic pa, pb;
    int n;
    pa = av; pb = bv; aw = 0; bw = 0; n = 0;
    a_valid = av; a_we = awe; a_addr = aad; a_wd = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wd = bwd;
    while ((pa || pb) && n < 20) begin
      @(negedge clk);
      if (pa && a_ready) begin
        if (!awe) qa.push_back(aexp);
        pa = 1'b0;
      end else if (pa) aw++;
      if (pb && b_ready) begin
        if (!bwe) qb.push_back(bexp);
        pb = 1'b0;
      end else if (pb) bw++;
      @(posedge clk); #1;
      if (!pa) a_valid = 1'b0;
      if (!pb) b_valid = 1'b0;
      n++;
    end
    if (pa || pb) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got pending a=%0b b=%0b, expected accepted", pa, pb);
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
  endtask

  initial begin
    int aw, bw, sa, sb;
    logic [15:0] c0;
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw, bw, sa, sb;
    logic [15:0] c0;
    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wd = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    a_valid = 1'b1;
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    a_valid = 1'b0;
    chk("rst_ram_a_a", 64'(ram_a_a), 64'd0);
    chk("rst_ram_we_b", 64'(ram_we_b), 64'd0);
    chk("rst_ram_wd_a", 64'(ram_wd_a), 64'd0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_b_rd", 64'(b_rd), 64'd0);
    chk("rst_coll_cnt", 64'(coll_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-port write then read-back
    req2(1, 1, 10'h2A5, 36'h123456789, 0, 0, 0, 0, 0, 0, aw, bw);
    req2(1, 0, 10'h2A5, 0, 36'h123456789, 0, 0, 0, 0, 0, aw, bw);
    drain();
    chk("t1_rva", 64'(rva), 64'd1);
    chk("t1_coll", 64'(coll_cnt), 64'd0);

    // WW, prio=0: A first
    req2(1, 1, 10'h010, 36'h1, 0, 1, 1, 10'h010, 36'h2, 0, aw, bw);
    chk("ww1_a_wait", 64'(aw), 64'd0);
    chk("ww1_b_wait", 64'(bw), 64'd1);
    repeat (2) @(posedge clk); #1;
    chk("ww1_we_gap", 64'(we_b_cyc - we_a_cyc), 64'd1);
    chk("ww1_coll", 64'(coll_cnt), 64'd1);
    req2(1, 0, 10'h010, 0, 36'h2, 0, 0, 0, 0, 0, aw, bw);
    drain();

    // WW again: B wins
    req2(1, 1, 10'h010, 36'h1, 0, 1, 1, 10'h010, 36'h2, 0, aw, bw);
    chk("ww2_a_wait", 64'(aw), 64'd1);
    chk("ww2_b_wait", 64'(bw), 64'd0);
    chk("ww2_coll", 64'(coll_cnt), 64'd2);
    req2(0, 0, 0, 0, 0, 1, 0, 10'h010, 0, 36'h1, aw, bw);
    drain();

    // RW: A writes, B reads same address
    c0 = coll_cnt;
    req2(1, 1, 10'h3FF, 36'hAAA, 0, 1, 0, 10'h3FF, 0, 36'hAAA, aw, bw);
    chk("rw_a_wait", 64'(aw), 64'd0);
    chk("rw_b_wait", 64'(bw), FWD ? 64'd0 : 64'd1);
    drain();
    chk("rw_coll", 64'(coll_cnt), 64'(c0) + (FWD ? 64'd0 : 64'd1));

    // RW mirrored: B writes, A reads
    c0 = coll_cnt;
    req2(1, 0, 10'h155, 0, 36'hBEEF, 1, 1, 10'h155, 36'hBEEF, 0, aw, bw);
    chk("rw2_a_wait", 64'(aw), FWD ? 64'd0 : 64'd1);
    drain();
    chk("rw2_coll", 64'(coll_cnt), 64'(c0) + (FWD ? 64'd0 : 64'd1));

    // sustained hazard-free dual reads
    c0 = coll_cnt; rva = 0; rvb = 0; sa = 0; sb = 0;
    for (int i = 0; i < 100; i++) begin
      req2(1, 0, 10'h005, 0, 36'h0, 1, 0, 10'h006, 0, 36'h0, aw, bw);
      sa += aw;
      sb += bw;
    end
    drain();
    chk("rr_a_stall", 64'(sa), 64'd0);
    chk("rr_b_stall", 64'(sb), 64'd0);
    chk("rr_rva", 64'(rva), 64'd100);
    chk("rr_rvb", 64'(rvb), 64'd100);
    chk("rr_coll", 64'(coll_cnt), 64'(c0));

    // reset while a read is in flight
    rva = 0;
    req2(1, 0, 10'h2A5, 0, 36'h123456789, 0, 0, 0, 0, 0, aw, bw);
    rst_n = 1'b0;
    a_valid = 1'b1;
    #1;
    chk("mid_a_ready", 64'(a_ready), 64'd0);
    chk("mid_ram_a_a", 64'(ram_a_a), 64'd0);
    chk("mid_ram_we_a", 64'(ram_we_a), 64'd0);
    chk("mid_a_rvalid", 64'(a_rvalid), 64'd0);
    chk("mid_coll", 64'(coll_cnt), 64'd0);
    a_valid = 1'b0;
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("mid_no_rvalid", 64'(rva), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
